// File: rtl/rv_pkg.sv
// Shared RV32I definitions: data width, branch funct3 encodings and the default reset vector.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch-condition decode from funct3 and the ALU compare flags.
module branch_cond
  import rv_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_eq,
  input  logic       i_slt,
  output logic       o_cond,
  output logic       o_alu_unsigned
);

  // funct3[1] selects the unsigned compare for BLTU/BGEU.
  assign o_alu_unsigned = i_funct3[1];

  always_comb begin
    o_cond = 1'b0;
    case (i_funct3)
      F3_BEQ:           o_cond = i_eq;
      F3_BNE:           o_cond = ~i_eq;
      F3_BLT, F3_BLTU:  o_cond = i_slt;
      F3_BGE, F3_BGEU:  o_cond = ~i_slt;
      default:          o_cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_pc_unit.sv
// PC register, next-PC selection and misaligned-target halt for the single-cycle RV32I core.
// Optional branch performance counters are enabled by defining BRANCH_PC_PERF_EN.
module branch_pc_unit
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_ADDR = RESET_VECTOR
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_branch,
  input  logic            i_jal,
  input  logic            i_jalr,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1,
  input  logic            i_eq,
  input  logic            i_slt,
  output logic            o_alu_unsigned,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_taken,
  output logic            o_halt,
  output logic [XLEN-1:0] o_br_total,
  output logic [XLEN-1:0] o_br_taken
);

  logic            cond;
  logic            funct_unsigned;
  logic [XLEN-1:0] pc_q;
  logic            halt_q;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] next_pc;
  logic            redirect;
  logic            taken;
  logic            misaligned;

  branch_cond u_branch_cond (
    .i_funct3       (i_funct3),
    .i_eq           (i_eq),
    .i_slt          (i_slt),
    .o_cond         (cond),
    .o_alu_unsigned (funct_unsigned)
  );

  assign o_alu_unsigned = i_branch & funct_unsigned;

  // Next-PC selection: JALR > JAL > taken branch > sequential; frozen while halted.
  always_comb begin
    br_target   = pc_q + i_imm;
    jalr_sum    = i_rs1 + i_imm;
    jalr_target = {jalr_sum[XLEN-1:1], 1'b0};
    pc_plus4    = pc_q + XLEN'(4);
    redirect    = i_jalr | i_jal | (i_branch & cond);
    next_pc     = pc_plus4;
    if (halt_q)
      next_pc = pc_q;
    else if (i_jalr)
      next_pc = jalr_target;
    else if (i_jal || (i_branch && cond))
      next_pc = br_target;
    taken      = redirect & ~halt_q & ~i_stall;
    misaligned = taken & (next_pc[1:0] != 2'b00);
  end

  // A misaligned redirect traps instead of updating the PC; only reset clears the halt.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q   <= RESET_ADDR;
      halt_q <= 1'b0;
    end else if (!i_stall && !halt_q) begin
      if (misaligned)
        halt_q <= 1'b1;
      else
        pc_q <= next_pc;
    end
  end

  assign o_pc       = pc_q;
  assign o_pc_plus4 = pc_plus4;
  assign o_next_pc  = next_pc;
  assign o_taken    = taken;
  assign o_halt     = halt_q;

`ifdef BRANCH_PC_PERF_EN
  logic [XLEN-1:0] br_total_q;
  logic [XLEN-1:0] br_taken_q;

  // Saturating counters of executed and taken branches.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      br_total_q <= '0;
      br_taken_q <= '0;
    end else if (!i_stall && !halt_q && i_branch) begin
      if (br_total_q != '1)
        br_total_q <= br_total_q + XLEN'(1);
      if (cond && (br_taken_q != '1))
        br_taken_q <= br_taken_q + XLEN'(1);
    end
  end

  assign o_br_total = br_total_q;
  assign o_br_taken = br_taken_q;
`else
  assign o_br_total = '0;
  assign o_br_taken = '0;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: table-driven decode vectors plus reset, halt, stall, wrap and perf sequences.
module tb_branch_pc_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch;
  logic        jal;
  logic        jalr;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        eq;
  logic        slt;
  logic        alu_unsigned;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        taken;
  logic        halt;
  logic [31:0] br_total;
  logic [31:0] br_taken;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        stall;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        eq;
    logic        slt;
  } ctrl_t;

  typedef struct {
    string       name;
    logic [31:0] start_pc;
    ctrl_t       c;
    logic [31:0] exp_next;
    logic        exp_taken;
    logic        exp_uns;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        halt;
  } exp_t;

  exp_t  sb[$];
  vec_t  vecs[11];
  ctrl_t idle_c;

  branch_pc_unit #(.RESET_ADDR(32'h0000_1000)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_stall        (stall),
    .i_branch       (branch),
    .i_jal          (jal),
    .i_jalr         (jalr),
    .i_funct3       (funct3),
    .i_imm          (imm),
    .i_rs1          (rs1),
    .i_eq           (eq),
    .i_slt          (slt),
    .o_alu_unsigned (alu_unsigned),
    .o_pc           (pc),
    .o_pc_plus4     (pc_plus4),
    .o_next_pc      (next_pc),
    .o_taken        (taken),
    .o_halt         (halt),
    .o_br_total     (br_total),
    .o_br_taken     (br_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic apply(input ctrl_t c);
    stall  = c.stall;
    branch = c.branch;
    jal    = c.jal;
    jalr   = c.jalr;
    funct3 = c.f3;
    imm    = c.imm;
    rs1    = c.rs1;
    eq     = c.eq;
    slt    = c.slt;
  endtask

  // Push the expected post-edge state, clock once, then pop and compare.
  task automatic cycle(input string nm, input logic [31:0] epc, input logic ehalt);
    exp_t e;
    sb.push_back('{nm, epc, ehalt});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.name, ".pc"}, pc, e.pc);
    chk({e.name, ".halt"}, 32'(halt), 32'(e.halt));
  endtask

  task automatic set_pc(input logic [31:0] target);
    ctrl_t c;
    c = idle_c;
    c.jalr = 1'b1;
    c.rs1  = target;
    apply(c);
    cycle("preset", target, 1'b0);
  endtask

  function automatic ctrl_t br(input logic [2:0] f3, input logic e, input logic s, input logic [31:0] im);
    ctrl_t c;
    c = '{1'b0, 1'b1, 1'b0, 1'b0, f3, im, 32'h0, e, s};
    return c;
  endfunction

  initial begin
    ctrl_t c;
    idle_c = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0};

    vecs[0]  = '{"beq_eq",   32'h100, br(3'b000, 1'b1, 1'b0, 32'h20), 32'h120, 1'b1, 1'b0, 32'h120};
    vecs[1]  = '{"bne_eq",   32'h100, br(3'b001, 1'b1, 1'b0, 32'h20), 32'h104, 1'b0, 1'b0, 32'h104};
    vecs[2]  = '{"bltu_slt", 32'h100, br(3'b110, 1'b0, 1'b1, 32'h20), 32'h120, 1'b1, 1'b1, 32'h120};
    vecs[3]  = '{"f3_010",   32'h100, br(3'b010, 1'b1, 1'b1, 32'h20), 32'h104, 1'b0, 1'b1, 32'h104};
    vecs[4]  = '{"bge_nslt", 32'h100, br(3'b101, 1'b0, 1'b0, 32'h20), 32'h120, 1'b1, 1'b0, 32'h120};
    vecs[5]  = '{"blt_nslt", 32'h100, br(3'b100, 1'b0, 1'b0, 32'h20), 32'h104, 1'b0, 1'b0, 32'h104};
    vecs[6]  = '{"bgeu_slt", 32'h100, br(3'b111, 1'b0, 1'b1, 32'h20), 32'h104, 1'b0, 1'b1, 32'h104};
    vecs[7]  = '{"jal_neg",  32'h200, '{1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b0},
                 32'h1F0, 1'b1, 1'b0, 32'h1F0};
    vecs[8]  = '{"jalr",     32'h200, '{1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 32'h4, 32'h301, 1'b0, 1'b0},
                 32'h304, 1'b1, 1'b0, 32'h304};
    vecs[9]  = '{"jal_jalr", 32'h200, '{1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 32'h4, 32'h301, 1'b0, 1'b0},
                 32'h304, 1'b1, 1'b0, 32'h304};
    vecs[10] = '{"jal_fwd",  32'h200, '{1'b0, 1'b0, 1'b1, 1'b0, 3'b110, 32'h40, 32'h0, 1'b0, 1'b0},
                 32'h240, 1'b1, 1'b0, 32'h240};

    // Reset held two cycles, then free-running sequential flow.
    apply(idle_c);
    rst = 1'b1;
    cycle("rst0", 32'h1000, 1'b0);
    cycle("rst1", 32'h1000, 1'b0);
    chk("rst.pc_plus4", pc_plus4, 32'h1004);
    chk("rst.br_total", br_total, 32'h0);
    chk("rst.br_taken", br_taken, 32'h0);
    rst = 1'b0;
    cycle("seq0", 32'h1004, 1'b0);
    cycle("seq1", 32'h1008, 1'b0);

    // Decode and next-PC table.
    for (int i = 0; i < 11; i++) begin
      set_pc(vecs[i].start_pc);
      apply(vecs[i].c);
      #1;
      chk({vecs[i].name, ".next_pc"}, next_pc, vecs[i].exp_next);
      chk({vecs[i].name, ".taken"}, 32'(taken), 32'(vecs[i].exp_taken));
      chk({vecs[i].name, ".alu_uns"}, 32'(alu_unsigned), 32'(vecs[i].exp_uns));
      cycle(vecs[i].name, vecs[i].exp_pc, 1'b0);
    end

    // Misaligned JAL traps, later legal JALs are ignored, reset clears the halt.
    set_pc(32'h400);
    c = idle_c;
    c.jal = 1'b1;
    c.imm = 32'h6;
    apply(c);
    #1;
    chk("mis.taken", 32'(taken), 32'h1);
    cycle("mis.trap", 32'h400, 1'b1);
    c.imm = 32'h8;
    apply(c);
    #1;
    chk("mis.held_taken", 32'(taken), 32'h0);
    chk("mis.held_next", next_pc, 32'h400);
    cycle("mis.held0", 32'h400, 1'b1);
    cycle("mis.held1", 32'h400, 1'b1);
    apply(idle_c);
    rst = 1'b1;
    cycle("mis.rst", 32'h1000, 1'b0);
    rst = 1'b0;

    // Stall holds PC while decode stays observable.
    set_pc(32'h100);
    c = br(3'b000, 1'b1, 1'b0, 32'h20);
    c.stall = 1'b1;
    apply(c);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall.taken", 32'(taken), 32'h0);
      chk("stall.next", next_pc, 32'h120);
      cycle("stall", 32'h100, 1'b0);
    end
    c.stall = 1'b0;
    apply(c);
    cycle("stall.release", 32'h120, 1'b0);

    // Sequential wrap at the top of the address space.
    set_pc(32'hFFFF_FFFC);
    apply(idle_c);
    #1;
    chk("wrap.pc_plus4", pc_plus4, 32'h0);
    cycle("wrap", 32'h0, 1'b0);

    // Perf counters: 5 executed branches (3 taken) plus one stalled branch.
    rst = 1'b1;
    cycle("perf.rst", 32'h1000, 1'b0);
    rst = 1'b0;
    apply(br(3'b000, 1'b1, 1'b0, 32'h8));
    cycle("perf.b0", 32'h1008, 1'b0);
    apply(br(3'b001, 1'b1, 1'b0, 32'h8));
    cycle("perf.b1", 32'h100C, 1'b0);
    apply(br(3'b100, 1'b0, 1'b1, 32'h8));
    cycle("perf.b2", 32'h1014, 1'b0);
    apply(br(3'b101, 1'b0, 1'b1, 32'h8));
    cycle("perf.b3", 32'h1018, 1'b0);
    c = br(3'b000, 1'b1, 1'b0, 32'h8);
    c.stall = 1'b1;
    apply(c);
    cycle("perf.stall", 32'h1018, 1'b0);
    apply(br(3'b111, 1'b0, 1'b0, 32'h8));
    cycle("perf.b4", 32'h1020, 1'b0);
    apply(idle_c);
`ifdef BRANCH_PC_PERF_EN
    chk("perf.br_total", br_total, 32'd5);
    chk("perf.br_taken", br_taken, 32'd3);
`else
    chk("perf.br_total", br_total, 32'd0);
    chk("perf.br_taken", br_taken, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Program-counter and branch-resolution unit for the single-cycle RV32I core.
- Sits on the consuming end of the ALU's comparison outputs (o_eq, o_slt).
- Drives the ALU's i_unsigned for B-type instructions, evaluates the branch condition from funct3, and computes the next PC for sequential, branch, JAL and JALR flow.
- Owns the architectural PC register and a sticky misaligned-target halt.

Parameters:
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.

Ports:
- i_clk  in  1  system clock; all state updates on its rising edge
- i_rst  in  1  synchronous, active-high reset
- i_stall  in  1  hold PC and all state this cycle
- i_branch  in  1  current instruction is B-type
- i_jal  in  1  current instruction is JAL
- i_jalr  in  1  current instruction is JALR
- i_funct3  in  3  instruction funct3
- i_imm  in  32  sign-extended immediate (B/J/I format)
- i_rs1  in  32  rs1 value (JALR base)
- i_eq  in  1  ALU o_eq
- i_slt  in  1  ALU o_slt
- o_alu_unsigned  out  1  to ALU i_unsigned; equals i_funct3[1] when i_branch, else 0
- o_pc  out  32  current PC (registered)
- o_pc_plus4  out  32  o_pc + 4, modulo 2^32 (rd value for JAL/JALR)
- o_next_pc  out  32  combinational next PC
- o_taken  out  1  combinational: redirect (branch taken, JAL or JALR) this cycle
- o_halt  out  1  sticky misaligned-target halt (registered)
- o_br_total  out  32  branches executed (perf feature)
- o_br_taken  out  32  branches taken (perf feature)

Behaviour:
- Reset (sync, active-high, overrides everything including i_stall and o_halt):
  - o_pc = RESET_ADDR, o_halt = 0, counters = 0.
- Branch condition, decoded from i_funct3:
  - 000 BEQ: i_eq
  - 001 BNE: !i_eq
  - 100 BLT and 110 BLTU: i_slt
  - 101 BGE and 111 BGEU: !i_slt
  - 010 and 011: illegal, never taken
- Target computation (all adds modulo 2^32, carry discarded):
  - Branch and JAL: o_pc + i_imm.
  - JALR: (i_rs1 + i_imm) with bit 0 cleared.
- Next-PC priority, highest first: i_jalr > i_jal > taken branch > o_pc + 4.
  - If i_jal and i_jalr are both asserted, JALR wins.
- o_taken = i_jalr | i_jal | (i_branch & cond).
  - Forced 0 while o_halt or i_stall is set.
- Misaligned target: o_taken would be 1 and target[1:0] != 0.
  - PC does not update.
  - o_halt sets on that edge and stays set until reset.
  - Only the target is checked; a not-taken branch never traps.
- While o_halt = 1: o_pc frozen, o_next_pc = o_pc, counters frozen.
- i_stall = 1: o_pc and counters hold. o_next_pc still reflects the decode for observation.
- Latency: a redirect is visible on o_pc one cycle after the edge that samples it. No bubbles are inserted.
- Wrap-around: o_pc = 32'hFFFF_FFFC with sequential flow gives 32'h0000_0000; no trap.

Optional Feature:
- Macro: BRANCH_PC_PERF_EN.
- Defined:
  - o_br_total increments on each non-stalled, non-halted cycle with i_branch = 1.
  - o_br_taken increments on the same cycles when cond is also 1.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined:
  - No counter flops.
  - Both ports remain present and are tied to 0.

Decomposition:
- Shared package rv_pkg holds:
  - funct3 branch constants F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - Default reset vector constant.
- One natural sub-module: branch_cond.
  - Purely combinational; inputs funct3, i_eq, i_slt.
  - Outputs cond and o_alu_unsigned.
  - Reusable by a later pipelined core.

Test Plan:
- Reset: assert i_rst for 2 cycles with RESET_ADDR = 32'h0000_1000 -> o_pc = 0x1000, o_halt = 0. Release with no control inputs -> o_pc goes 0x1004, then 0x1008.
- Branch conditions, from PC 0x100, i_branch = 1, i_imm = 0x20:
  - BEQ, i_eq = 1 -> next o_pc = 0x120.
  - BNE, i_eq = 1 -> 0x104.
  - BLTU, i_slt = 1 -> 0x120, with o_alu_unsigned = 1.
  - funct3 = 010 -> 0x104.
- JAL/JALR priority, PC 0x200:
  - JAL, imm = 0xFFFF_FFF0 -> 0x1F0.
  - JALR, rs1 = 0x301, imm = 0x4 -> 0x304.
  - Both asserted -> 0x304.
- Misaligned: JAL from 0x400 with imm = 0x6 -> o_pc stays 0x400, o_halt = 1. Later legal JALs are ignored. i_rst clears o_halt.
- Stall and wrap:
  - i_stall = 1 with a taken BEQ for 3 cycles -> o_pc held.
  - PC 0xFFFF_FFFC with no control -> next o_pc = 0x0.
- Perf (BRANCH_PC_PERF_EN defined): 5 branches, 3 taken, one stalled cycle carrying a branch -> o_br_total = 5, o_br_taken = 3. With the macro undefined, both read 0.
